// File: rtl/rib_flash_reader_pkg.sv
// rtl/rib_flash_reader_pkg.sv - shared constants and types for the RIB flash reader
package rib_flash_reader_pkg;

    localparam logic [7:0] FLASH_CMD_READ = 8'h03;
    localparam int         FLASH_BITS     = 64;

    typedef enum logic [2:0] {
        FL_IDLE,
        FL_CMD,
        FL_ADDR,
        FL_DATA,
        FL_DONE
    } flash_rd_state_e;

    // The first byte shifted in from the flash lands in the top byte of the
    // receive window; the bus wants it in the lowest byte.
    function automatic logic [31:0] le_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/rib_flash_reader_sck_gen.sv
// rtl/rib_flash_reader_sck_gen.sv - SPI mode-0 clock divider with edge strobes
module spi_sck_gen
    import rib_flash_reader_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sck_o,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic          half_done;

    // Strobes are high in the cycle whose closing edge toggles SCK, so the
    // consumer acts on exactly the edge where SCK changes.
    assign half_done = en && (div_cnt == LAST);
    assign rise_stb  = half_done && !sck_o;
    assign fall_stb  = half_done && sck_o;

    // Half-period counter and SCK register; both park at zero while disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck_o   <= 1'b0;
        end else if (half_done) begin
            div_cnt <= '0;
            sck_o   <= !sck_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rib_flash_reader.sv
// rtl/rib_flash_reader.sv - read-only RIB slave window onto an SPI NOR flash
module rib_flash_reader
    import rib_flash_reader_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter logic [7:0] READ_CMD = FLASH_CMD_READ
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        busy_o,
    output logic        spi_cs_n_o,
    output logic        spi_sck_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    flash_rd_state_e state;
    logic [63:0]     shreg;
    logic [5:0]      bit_cnt;
    logic            rise_stb;
    logic            fall_stb;
    logic            rd_start;
    logic            unused_bits;

    // Writes, the region nibble and the byte offset within a word carry no meaning here.
    assign unused_bits = ^{data_i, addr_i[31:24], addr_i[1:0]};
    assign rd_start    = req_i & ~we_i;

    spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (!spi_cs_n_o),
        .sck_o    (spi_sck_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Stall the bus from the request cycle until the word is ready.
    always_comb begin
        busy_o = 1'b0;
        case (state)
            FL_IDLE:                  busy_o = rd_start;
            FL_CMD, FL_ADDR, FL_DATA: busy_o = 1'b1;
            default:                  busy_o = 1'b0;
        endcase
    end

    // Transaction sequencer: one shift register carries command/address out
    // and, after it has been shifted past, collects the returned data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FL_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_o     <= '0;
            spi_cs_n_o <= 1'b1;
            spi_mosi_o <= 1'b0;
        end else begin
            case (state)
                FL_IDLE: begin
                    if (rd_start) begin
                        shreg      <= {READ_CMD, addr_i[23:2], 2'b00, 32'h0};
                        bit_cnt    <= '0;
                        spi_mosi_o <= READ_CMD[7];
                        spi_cs_n_o <= 1'b0;
                        state      <= FL_CMD;
                    end
                end
                FL_CMD, FL_ADDR, FL_DATA: begin
                    if (rise_stb) begin
                        shreg <= {shreg[62:0], (state == FL_DATA) ? spi_miso_i : 1'b0};
                    end
                    if (fall_stb) begin
                        bit_cnt    <= bit_cnt + 6'd1;
                        spi_mosi_o <= shreg[63];
                        if (bit_cnt == 6'd7) begin
                            state <= FL_ADDR;
                        end
                        if (bit_cnt == 6'd31) begin
                            state <= FL_DATA;
                        end
                        if (bit_cnt == 6'(FLASH_BITS - 1)) begin
                            state      <= FL_DONE;
                            spi_cs_n_o <= 1'b1;
                            spi_mosi_o <= 1'b0;
                            data_o     <= le_bytes(shreg[31:0]);
                        end
                    end
                end
                FL_DONE: state <= FL_IDLE;
                default: state <= FL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_flash_reader.sv
// tb/tb_rib_flash_reader.sv - self-checking bench for rib_flash_reader
module tb_rib_flash_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  busy;
    logic [1:0]  cs_n;
    logic [1:0]  sck;
    logic [1:0]  mosi;
    logic [1:0]  miso = 2'b00;
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic [31:0] data_v  [2];
    int          div_of  [2] = '{2, 1};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rib_flash_reader #(.CLK_DIV(2)) u_dut_div2 (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req[0]),
        .we_i       (we[0]),
        .addr_i     (addr_v[0]),
        .data_i     (wdata_v[0]),
        .data_o     (data_v[0]),
        .busy_o     (busy[0]),
        .spi_cs_n_o (cs_n[0]),
        .spi_sck_o  (sck[0]),
        .spi_mosi_o (mosi[0]),
        .spi_miso_i (miso[0])
    );

    rib_flash_reader #(.CLK_DIV(1)) u_dut_div1 (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req[1]),
        .we_i       (we[1]),
        .addr_i     (addr_v[1]),
        .data_i     (wdata_v[1]),
        .data_o     (data_v[1]),
        .busy_o     (busy[1]),
        .spi_cs_n_o (cs_n[1]),
        .spi_sck_o  (sck[1]),
        .spi_mosi_o (mosi[1]),
        .spi_miso_i (miso[1])
    );

    // Flash array contents
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h11;
            24'h000101: return 8'h22;
            24'h000102: return 8'h33;
            24'h000103: return 8'h44;
            24'h000104: return 8'h55;
            24'h000105: return 8'h66;
            24'h000106: return 8'h77;
            24'h000107: return 8'h88;
            24'hFFFFFC: return 8'hA1;
            24'hFFFFFD: return 8'hB2;
            24'hFFFFFE: return 8'hC3;
            24'hFFFFFF: return 8'hD4;
            default:    return (a[7:0] * 8'd37) ^ a[15:8] ^ (a[23:16] + 8'd3);
        endcase
    endfunction

    // Word the bus should see for a read at address a
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [23:0] base;
        base = {a[23:2], 2'b00};
        return {flash_byte(base + 24'd3), flash_byte(base + 24'd2),
                flash_byte(base + 24'd1), flash_byte(base)};
    endfunction

    // SPI mode-0 flash model, observed once per clk at the falling clk edge
    int          nbits  [2] = '{0, 0};
    int          rises  [2] = '{0, 0};
    int          frames [2] = '{0, 0};
    logic [31:0] cap    [2];
    logic [1:0]  sck_prev = 2'b00;
    logic [1:0]  cs_prev  = 2'b11;
    logic [7:0]  fb_tmp;
    int          idx;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cs_n[k] !== 1'b0) nbits[k] = 0;
            if (cs_prev[k] && cs_n[k] === 1'b0) frames[k]++;
            if (sck[k] === 1'b1 && !sck_prev[k]) begin
                rises[k]++;
                if (cs_n[k] === 1'b0) begin
                    if (nbits[k] < 32) cap[k] = {cap[k][30:0], mosi[k]};
                    nbits[k]++;
                end
            end
            if (sck[k] === 1'b0 && sck_prev[k] && cs_n[k] === 1'b0 &&
                nbits[k] >= 32 && nbits[k] < 64) begin
                idx     = nbits[k] - 32;
                fb_tmp  = flash_byte(cap[k][23:0] + 24'(idx / 8));
                miso[k] = fb_tmp[7 - (idx % 8)];
            end
            sck_prev[k] = (sck[k] === 1'b1);
            cs_prev[k]  = (cs_n[k] !== 1'b0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus read on instance k; keep leaves req asserted into the next IDLE cycle
    task automatic do_read(input bit k, input logic [31:0] a, input logic [31:0] exp,
                           input bit keep, input bit scramble);
        int          n;
        logic [31:0] exp_cap;
        exp_cap   = {8'h03, a[23:2], 2'b00};
        req[k]    = 1'b1;
        we[k]     = 1'b0;
        addr_v[k] = a;
        #1;
        n = 0;
        while (busy[k] === 1'b1 && n < 2000) begin
            n++;
            if (scramble && n == 10) begin
                addr_v[k] = $urandom;
                we[k]     = 1'($urandom);
                req[k]    = 1'($urandom);
            end
            @(negedge clk);
            #1;
        end
        check("busy_len", 32'(n), 32'(1 + 128 * div_of[k]));
        check("rd_data", data_v[k], exp);
        check("mosi_hdr", cap[k], exp_cap);
        check("done_cs_n", 32'(cs_n[k]), 32'd1);
        if (keep) begin
            @(negedge clk);
            #1;
            check("rehold_busy", 32'(busy[k]), 32'd1);
        end else begin
            req[k] = 1'b0;
            we[k]  = 1'b0;
            @(negedge clk);
            #1;
            check("idle_busy", 32'(busy[k]), 32'd0);
            check("idle_sck", 32'(sck[k]), 32'd0);
            check("hold_data", data_v[k], exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs [6];
    int          r0, f0, bad;
    logic [31:0] d0, ra;
    bit          rk;

    initial begin
        vecs[0] = '{32'h7000_0100, 32'h4433_2211};
        vecs[1] = '{32'h7000_0103, 32'h4433_2211};
        vecs[2] = '{32'h7000_0104, 32'h8877_6655};
        vecs[3] = '{32'h7000_0107, 32'h8877_6655};
        vecs[4] = '{32'h70FF_FFFC, 32'hD4C3_B2A1};
        vecs[5] = '{32'h7FFF_FFFF, 32'hD4C3_B2A1};

        rst        = 1'b1;
        req        = 2'b00;
        we         = 2'b00;
        addr_v[0]  = '0;
        addr_v[1]  = '0;
        wdata_v[0] = '0;
        wdata_v[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(cs_n), 32'h3);
        check("rst_sck", 32'(sck), 32'h0);
        check("rst_mosi", 32'(mosi), 32'h0);
        check("rst_data", data_v[0], 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic read with the literal MOSI header
        do_read(1'b0, 32'h7000_0100, 32'h4433_2211, 1'b0, 1'b0);
        check("hdr_literal", cap[0], 32'h0300_0100);

        // Write is ignored
        r0 = rises[0];
        f0 = frames[0];
        d0 = data_v[0];
        bad = 0;
        req[0] = 1'b1;
        we[0] = 1'b1;
        addr_v[0] = 32'h7000_0100;
        wdata_v[0] = 32'hDEAD_BEEF;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1) bad++;
        end
        req[0] = 1'b0;
        we[0] = 1'b0;
        check("wr_busy_cs", 32'(bad), 32'd0);
        check("wr_no_sck", 32'(rises[0]), 32'(r0));
        check("wr_no_frame", 32'(frames[0]), 32'(f0));
        check("wr_data", data_v[0], d0);

        // Back-to-back reads with req held through DONE
        f0 = frames[0];
        do_read(1'b0, 32'h7000_0100, 32'h4433_2211, 1'b1, 1'b0);
        do_read(1'b0, 32'h7000_0104, 32'h8877_6655, 1'b0, 1'b0);
        check("b2b_frames", 32'(frames[0]), 32'(f0 + 2));

        // Vector table on the CLK_DIV=2 instance
        for (int i = 0; i < 6; i++) begin
            do_read(1'b0, vecs[i].addr, vecs[i].exp_data, 1'b0, 1'b0);
        end

        // Reset in the middle of a transfer
        req[0] = 1'b1;
        we[0] = 1'b0;
        addr_v[0] = 32'h7000_0104;
        repeat (100) @(negedge clk);
        check("mid_cs_n", 32'(cs_n[0]), 32'd0);
        rst = 1'b1;
        req[0] = 1'b0;
        #1;
        check("mid_rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("mid_rst_sck", 32'(sck[0]), 32'd0);
        check("mid_rst_data", data_v[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(1'b0, 32'h7000_0100, 32'h4433_2211, 1'b0, 1'b0);

        // CLK_DIV=1 instance, including SCK period check
        r0 = rises[1];
        do_read(1'b1, 32'h7000_0100, 32'h4433_2211, 1'b0, 1'b0);
        check("div1_rises", 32'(rises[1] - r0), 32'd64);
        do_read(1'b1, 32'h70FF_FFFC, 32'hD4C3_B2A1, 1'b0, 1'b0);

        // Random reads against the flash array, some with bus noise mid-transfer
        for (int i = 0; i < 12; i++) begin
            rk = 1'($urandom);
            ra = {4'h7, 28'($urandom)};
            do_read(rk, ra, ref_word(ra), 1'b0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
